hist_rank_sort: RTL and testbench
=================================

// Module: hist_rank_sort
// PURPOSE
//  Reader side of the spike-rate histogram: on each histogram-finish pulse, snapshots the
//  NUM_SYM frequency counts, sorts symbols by descending frequency, and publishes a
//  symbol->rank table and a rank->symbol table. Feeds the codeword assigner of the MUA
//  compressor, so the most frequent spike rate receives the shortest code.
// PARAMETERS
//  NUM_SYM   5   number of clipped spike-rate symbols (SPIKE_RATE_CLIP+1); fixed at 5
//  FREQ_BIT  10  width of each histogram frequency count
//  SYM_BIT   3   width of a symbol index / rank (clog2(NUM_SYM))
// PORTS
//  CLK          in   1           clock; all state on rising edge
//  RST          in   1           asynchronous reset, active-high
//  hist_finish  in   1           histogram-complete pulse from the histogram block
//  freq_in0..4  in   FREQ_BIT    frequency of symbol 0..4; valid while hist_finish=1
//  max_rate_in  in   SYM_BIT     histogram's running-max symbol (cross-check only)
//  sym_at_rank0..4 out SYM_BIT   symbol holding rank k (rank 0 = most frequent)
//  rank_of_sym0..4 out SYM_BIT   rank assigned to symbol s
//  table_valid  out  1           1-cycle pulse when both tables update
//  busy         out  1           high from capture until table_valid, inclusive
//  drop_err     out  1           sticky: hist_finish arrived while busy
//  max_mismatch out  1           sticky: sym_at_rank0 != captured max_rate_in (count differs)
// BEHAVIOUR
//  Reset: state IDLE; sym_at_rankk=k, rank_of_symk=k; table_valid, busy, drop_err,
//   max_mismatch = 0; snapshot regs = 0. Reset mid-sort aborts; tables return to identity.
//  FSM: IDLE -> LOAD -> SORT (pass 0..NUM_SYM-1) -> EMIT -> IDLE.
//   IDLE: hist_finish=1 (level sampled) -> LOAD. Capture freq_in*, max_rate_in that edge.
//   LOAD: init working arrays key[i]=freq_in i, idx[i]=i. busy=1.
//   SORT: odd-even transposition, 1 pass/cycle; even pass cmps (0,1),(2,3); odd pass
//    (1,2),(3,4). Swap iff key[lo] < key[hi], or key equal and idx[lo] > idx[hi].
//    Pass counter 0..4 (3 bits); exits after pass 4 (5 passes guarantee sorted for 5).
//   EMIT: sym_at_rankk <= idx[k]; rank_of_sym(idx[k]) <= k; table_valid=1 this cycle;
//    max_mismatch set if key of max_rate_in != key[0] (ties not flagged). -> IDLE.
//  Latency: hist_finish at cycle 0 -> table_valid high at cycle 7 (LOAD 1, SORT 5, EMIT 1).
//  Tables are held stable between EMITs; both update on the same edge (atomic).
//  Ordering: descending count; ties broken by lower symbol index ranking first (stable).
//  Comparisons unsigned, full FREQ_BIT width; no arithmetic, no overflow possible.
//  hist_finish while busy (LOAD/SORT/EMIT): ignored, drop_err <= 1 (cleared only by RST).
//  hist_finish held high across EMIT->IDLE: re-captured next cycle (level-sensitive).
//  All-zero counts: valid; result is identity order.
// STRUCTURE
//  Constants NUM_SYM, FREQ_BIT, SYM_BIT belong in params.v alongside SPIKE_RATE_CLIP.
//  One sub-module: hist_cas (compare-and-swap of {key,idx} pair with tie rule), instanced
//  twice per pass; mux selects odd/even pairing. Remainder: FSM + pass counter + tables.
// TESTING
//  Distinct: freq={3,9,1,7,5} -> sym_at_rank={1,3,4,0,2}, rank_of_sym={3,0,4,1,2},
//   table_valid exactly 7 cycles after hist_finish.
//  All equal: freq={4,4,4,4,4} -> identity tables; max_mismatch stays 0.
//  Ascending: freq={1,2,3,4,5}, max_rate_in=4 -> sym_at_rank={4,3,2,1,0}; max_mismatch=0.
//  Busy overlap: second hist_finish 3 cycles after first -> drop_err=1, tables from first only.
//  Reset at pass 2 -> all outputs identity/0 next cycle; next hist_finish sorts normally.
//  Max cross-check: freq={0,0,8,0,0}, max_rate_in=1 -> max_mismatch=1 after EMIT.

Source files
------------

// File: rtl/hist_rank_sort_pkg.sv
// rtl/hist_rank_sort_pkg.sv - shared sizes, types and tie-break rule for the rank sorter
package hist_rank_sort_pkg;
  localparam int NUM_SYM  = 5;
  localparam int FREQ_BIT = 10;
  localparam int SYM_BIT  = 3;

  typedef logic [FREQ_BIT-1:0] freq_t;
  typedef logic [SYM_BIT-1:0]  sym_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_EMIT} state_t;

  localparam sym_t LAST_SYM  = sym_t'(NUM_SYM - 1);
  localparam sym_t LAST_PASS = sym_t'(NUM_SYM - 1);

  // Higher count moves toward rank 0; equal counts keep the lower symbol first.
  function automatic logic cas_swap(input freq_t k_lo, input sym_t i_lo,
                                    input freq_t k_hi, input sym_t i_hi);
    return (k_lo < k_hi) || ((k_lo == k_hi) && (i_lo > i_hi));
  endfunction
endpackage

// File: rtl/hist_cas.sv
// rtl/hist_cas.sv - compare-and-swap of one {key,idx} pair, descending with stable ties
module hist_cas
  import hist_rank_sort_pkg::*;
(
  input  logic [FREQ_BIT-1:0] key_lo_i,
  input  logic [SYM_BIT-1:0]  idx_lo_i,
  input  logic [FREQ_BIT-1:0] key_hi_i,
  input  logic [SYM_BIT-1:0]  idx_hi_i,
  output logic [FREQ_BIT-1:0] key_lo_o,
  output logic [SYM_BIT-1:0]  idx_lo_o,
  output logic [FREQ_BIT-1:0] key_hi_o,
  output logic [SYM_BIT-1:0]  idx_hi_o
);
  logic swap;

  assign swap     = cas_swap(key_lo_i, idx_lo_i, key_hi_i, idx_hi_i);
  assign key_lo_o = swap ? key_hi_i : key_lo_i;
  assign idx_lo_o = swap ? idx_hi_i : idx_lo_i;
  assign key_hi_o = swap ? key_lo_i : key_hi_i;
  assign idx_hi_o = swap ? idx_lo_i : idx_hi_i;
endmodule

// File: rtl/hist_rank_sort.sv
// rtl/hist_rank_sort.sv - snapshots histogram counts, odd-even sorts them, publishes rank tables
module hist_rank_sort
  import hist_rank_sort_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hist_finish_i,
  input  logic [FREQ_BIT-1:0] freq0_i,
  input  logic [FREQ_BIT-1:0] freq1_i,
  input  logic [FREQ_BIT-1:0] freq2_i,
  input  logic [FREQ_BIT-1:0] freq3_i,
  input  logic [FREQ_BIT-1:0] freq4_i,
  input  logic [SYM_BIT-1:0]  max_rate_i,
  output logic [SYM_BIT-1:0]  sym_at_rank0_o,
  output logic [SYM_BIT-1:0]  sym_at_rank1_o,
  output logic [SYM_BIT-1:0]  sym_at_rank2_o,
  output logic [SYM_BIT-1:0]  sym_at_rank3_o,
  output logic [SYM_BIT-1:0]  sym_at_rank4_o,
  output logic [SYM_BIT-1:0]  rank_of_sym0_o,
  output logic [SYM_BIT-1:0]  rank_of_sym1_o,
  output logic [SYM_BIT-1:0]  rank_of_sym2_o,
  output logic [SYM_BIT-1:0]  rank_of_sym3_o,
  output logic [SYM_BIT-1:0]  rank_of_sym4_o,
  output logic                table_valid_o,
  output logic                busy_o,
  output logic                drop_err_o,
  output logic                max_mismatch_o
);
  state_t state_q;
  sym_t   pass_q;
  sym_t   max_snap_q;
  freq_t  snap_q [NUM_SYM];
  freq_t  key_q  [NUM_SYM];
  sym_t   idx_q  [NUM_SYM];
  freq_t  key_d  [NUM_SYM];
  sym_t   idx_d  [NUM_SYM];
  sym_t   sym_at_rank_q [NUM_SYM];
  sym_t   rank_of_sym_q [NUM_SYM];
  sym_t   rank_d [NUM_SYM];
  freq_t  freq_in [NUM_SYM];
  logic   table_valid_q, busy_q, drop_err_q, max_mismatch_q;

  freq_t  ka_lo, ka_hi, kb_lo, kb_hi, ka_lo_s, ka_hi_s, kb_lo_s, kb_hi_s;
  sym_t   ia_lo, ia_hi, ib_lo, ib_hi, ia_lo_s, ia_hi_s, ib_lo_s, ib_hi_s;
  logic   odd;
  freq_t  max_key;
  logic   max_in_range;

  assign freq_in[0] = freq0_i;
  assign freq_in[1] = freq1_i;
  assign freq_in[2] = freq2_i;
  assign freq_in[3] = freq3_i;
  assign freq_in[4] = freq4_i;

  // Even passes pair (0,1),(2,3); odd passes pair (1,2),(3,4).
  assign odd   = pass_q[0];
  assign ka_lo = odd ? key_q[1] : key_q[0];
  assign ia_lo = odd ? idx_q[1] : idx_q[0];
  assign ka_hi = odd ? key_q[2] : key_q[1];
  assign ia_hi = odd ? idx_q[2] : idx_q[1];
  assign kb_lo = odd ? key_q[3] : key_q[2];
  assign ib_lo = odd ? idx_q[3] : idx_q[2];
  assign kb_hi = odd ? key_q[4] : key_q[3];
  assign ib_hi = odd ? idx_q[4] : idx_q[3];

  hist_cas u_cas_a (
    .key_lo_i(ka_lo),   .idx_lo_i(ia_lo),   .key_hi_i(ka_hi),   .idx_hi_i(ia_hi),
    .key_lo_o(ka_lo_s), .idx_lo_o(ia_lo_s), .key_hi_o(ka_hi_s), .idx_hi_o(ia_hi_s)
  );

  hist_cas u_cas_b (
    .key_lo_i(kb_lo),   .idx_lo_i(ib_lo),   .key_hi_i(kb_hi),   .idx_hi_i(ib_hi),
    .key_lo_o(kb_lo_s), .idx_lo_o(ib_lo_s), .key_hi_o(kb_hi_s), .idx_hi_o(ib_hi_s)
  );

  always_comb begin
    key_d = key_q;
    idx_d = idx_q;
    if (odd) begin
      key_d[1] = ka_lo_s; idx_d[1] = ia_lo_s;
      key_d[2] = ka_hi_s; idx_d[2] = ia_hi_s;
      key_d[3] = kb_lo_s; idx_d[3] = ib_lo_s;
      key_d[4] = kb_hi_s; idx_d[4] = ib_hi_s;
    end else begin
      key_d[0] = ka_lo_s; idx_d[0] = ia_lo_s;
      key_d[1] = ka_hi_s; idx_d[1] = ia_hi_s;
      key_d[2] = kb_lo_s; idx_d[2] = ib_lo_s;
      key_d[3] = kb_hi_s; idx_d[3] = ib_hi_s;
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SYM; s++) rank_d[s] = '0;
    for (int k = 0; k < NUM_SYM; k++) begin
      for (int s = 0; s < NUM_SYM; s++) begin
        if (idx_q[k] == sym_t'(s)) rank_d[s] = sym_t'(k);
      end
    end
  end

  // An out-of-range max symbol can never agree with the sorted head, so it flags.
  always_comb begin
    max_key = '0;
    for (int s = 0; s < NUM_SYM; s++) begin
      if (max_snap_q == sym_t'(s)) max_key = snap_q[s];
    end
  end
  assign max_in_range = (max_snap_q <= LAST_SYM);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      pass_q         <= '0;
      max_snap_q     <= '0;
      table_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      drop_err_q     <= 1'b0;
      max_mismatch_q <= 1'b0;
      for (int i = 0; i < NUM_SYM; i++) begin
        snap_q[i]        <= '0;
        key_q[i]         <= '0;
        idx_q[i]         <= sym_t'(i);
        sym_at_rank_q[i] <= sym_t'(i);
        rank_of_sym_q[i] <= sym_t'(i);
      end
    end else begin
      table_valid_q <= 1'b0;
      if ((state_q != S_IDLE) && hist_finish_i) drop_err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          busy_q <= hist_finish_i;
          if (hist_finish_i) begin
            for (int i = 0; i < NUM_SYM; i++) snap_q[i] <= freq_in[i];
            max_snap_q <= max_rate_i;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < NUM_SYM; i++) begin
            key_q[i] <= snap_q[i];
            idx_q[i] <= sym_t'(i);
          end
          pass_q  <= '0;
          state_q <= S_SORT;
        end
        S_SORT: begin
          key_q  <= key_d;
          idx_q  <= idx_d;
          pass_q <= pass_q + 1'b1;
          if (pass_q == LAST_PASS) state_q <= S_EMIT;
        end
        S_EMIT: begin
          sym_at_rank_q <= idx_q;
          rank_of_sym_q <= rank_d;
          table_valid_q <= 1'b1;
          if (!max_in_range || (max_key != key_q[0])) max_mismatch_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sym_at_rank0_o = sym_at_rank_q[0];
  assign sym_at_rank1_o = sym_at_rank_q[1];
  assign sym_at_rank2_o = sym_at_rank_q[2];
  assign sym_at_rank3_o = sym_at_rank_q[3];
  assign sym_at_rank4_o = sym_at_rank_q[4];
  assign rank_of_sym0_o = rank_of_sym_q[0];
  assign rank_of_sym1_o = rank_of_sym_q[1];
  assign rank_of_sym2_o = rank_of_sym_q[2];
  assign rank_of_sym3_o = rank_of_sym_q[3];
  assign rank_of_sym4_o = rank_of_sym_q[4];
  assign table_valid_o  = table_valid_q;
  assign busy_o         = busy_q;
  assign drop_err_o     = drop_err_q;
  assign max_mismatch_o = max_mismatch_q;
endmodule

// File: tb/tb_hist_rank_sort.sv
// tb/tb_hist_rank_sort.sv - scoreboard bench for hist_rank_sort with directed sort vectors
module tb_hist_rank_sort;
  logic clk = 1'b0;
  logic rst, hist_finish;
  logic [9:0] f0, f1, f2, f3, f4;
  logic [2:0] max_rate;
  logic [2:0] sar0, sar1, sar2, sar3, sar4;
  logic [2:0] ros0, ros1, ros2, ros3, ros4;
  logic tv, busy, drop, mm;

  typedef struct packed {
    logic [14:0] sar;
    logic [14:0] ros;
    logic        mm;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hist_rank_sort dut (
    .clk_i(clk), .rst_i(rst), .hist_finish_i(hist_finish),
    .freq0_i(f0), .freq1_i(f1), .freq2_i(f2), .freq3_i(f3), .freq4_i(f4),
    .max_rate_i(max_rate),
    .sym_at_rank0_o(sar0), .sym_at_rank1_o(sar1), .sym_at_rank2_o(sar2),
    .sym_at_rank3_o(sar3), .sym_at_rank4_o(sar4),
    .rank_of_sym0_o(ros0), .rank_of_sym1_o(ros1), .rank_of_sym2_o(ros2),
    .rank_of_sym3_o(ros3), .rank_of_sym4_o(ros4),
    .table_valid_o(tv), .busy_o(busy), .drop_err_o(drop), .max_mismatch_o(mm)
  );

  function automatic logic [14:0] pk(input int a, input int b, input int c,
                                     input int d, input int x);
    return {x[2:0], d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic issue(input int a, input int b, input int c, input int d, input int x,
                       input int mr, input logic [14:0] sar, input logic [14:0] ros,
                       input logic emm, input bit push);
    exp_t t;
    @(negedge clk);
    f0 = 10'(a); f1 = 10'(b); f2 = 10'(c); f3 = 10'(d); f4 = 10'(x);
    max_rate = 3'(mr);
    hist_finish = 1'b1;
    if (push) begin
      t.sar = sar; t.ros = ros; t.mm = emm; t.cyc = 32'(cyc + 8);
      sb.push_back(t);
    end
    @(negedge clk);
    hist_finish = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_table_valid", 32'(sb.size()), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_identity(input string nm);
    chk({nm, "_sym_at_rank"}, 32'({sar4, sar3, sar2, sar1, sar0}), 32'(pk(0, 1, 2, 3, 4)));
    chk({nm, "_rank_of_sym"}, 32'({ros4, ros3, ros2, ros1, ros0}), 32'(pk(0, 1, 2, 3, 4)));
    chk({nm, "_table_valid"}, 32'(tv), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_drop_err"}, 32'(drop), 0);
    chk({nm, "_max_mismatch"}, 32'(mm), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && tv) begin
      if (sb.size() == 0) begin
        chk("unexpected_table_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sym_at_rank", 32'({sar4, sar3, sar2, sar1, sar0}), 32'(e.sar));
        chk("rank_of_sym", 32'({ros4, ros3, ros2, ros1, ros0}), 32'(e.ros));
        chk("max_mismatch", 32'(mm), 32'(e.mm));
        chk("latency_cycle", 32'(cyc), e.cyc);
        chk("busy_at_valid", 32'(busy), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hist_finish = 1'b0; max_rate = '0;
    f0 = '0; f1 = '0; f2 = '0; f3 = '0; f4 = '0;
    repeat (2) @(negedge clk);
    chk_identity("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(3, 9, 1, 7, 5, 1, pk(1, 3, 4, 0, 2), pk(3, 0, 4, 1, 2), 1'b0, 1'b1);
    wait_done();
    chk("busy_after_distinct", 32'(busy), 0);
    issue(4, 4, 4, 4, 4, 2, pk(0, 1, 2, 3, 4), pk(0, 1, 2, 3, 4), 1'b0, 1'b1);
    wait_done();
    issue(1, 2, 3, 4, 5, 4, pk(4, 3, 2, 1, 0), pk(4, 3, 2, 1, 0), 1'b0, 1'b1);
    wait_done();
    chk("drop_err_clean", 32'(drop), 0);

    issue(5, 0, 2, 8, 8, 3, pk(3, 4, 0, 2, 1), pk(2, 4, 3, 0, 1), 1'b0, 1'b1);
    @(negedge clk);
    issue(9, 1, 9, 1, 9, 0, '0, '0, 1'b0, 1'b0);
    wait_done();
    repeat (10) @(negedge clk);
    chk("drop_err_overlap", 32'(drop), 1);
    chk("busy_after_overlap", 32'(busy), 0);

    issue(7, 7, 1, 2, 3, 0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_mid_sort", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_identity("midsort_reset");
    rst = 1'b0;
    @(negedge clk);

    issue(2, 6, 6, 1, 0, 1, pk(1, 2, 0, 3, 4), pk(2, 0, 1, 3, 4), 1'b0, 1'b1);
    wait_done();
    issue(0, 0, 8, 0, 0, 1, pk(2, 0, 1, 3, 4), pk(1, 2, 0, 3, 4), 1'b1, 1'b1);
    wait_done();
    chk("max_mismatch_sticky", 32'(mm), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
